// File: rtl/backdoor_arbiter.sv
// Host-to-backdoor Wishbone arbiter: freezes the CPU system via halt on a sync boundary, then runs one beat to a ROM/RAM model.
// Optional ack timeout and error responses are enabled by defining BACKDOOR_TIMEOUT_EN.
module backdoor_arbiter #(
  parameter int NUM_ROMS       = 5,
  parameter int NUM_RAMS       = 2,
  parameter int SETTLE_CYCLES  = 2,
  parameter int HOLD_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int NT            = NUM_ROMS + NUM_RAMS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sync,
  output logic             halt,
  input  logic             wb_cyc_i,
  input  logic             wb_strobe_i,
  input  logic             wb_we_i,
  input  logic [31:0]      wb_addr_i,
  input  logic [31:0]      wb_data_i,
  output logic [31:0]      wb_data_o,
  output logic             wb_ack_o,
  output logic             wb_err_o,
  output logic [NT-1:0]    tgt_cyc_o,
  output logic [NT-1:0]    tgt_strobe_o,
  output logic             tgt_we_o,
  output logic [31:0]      tgt_addr_o,
  output logic [31:0]      tgt_data_o,
  input  logic [32*NT-1:0] tgt_data_i,
  input  logic [NT-1:0]    tgt_ack_i
);

`ifdef BACKDOOR_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    SYNC_WAIT,
    SETTLE,
    ACCESS,
    RESP,
    HOLD
  } state_t;

  state_t         state_reg, state_next;
  logic [15:0]    cnt_reg, cnt_next;
  logic [NT-1:0]  sel_reg, sel_next;
  logic [NT-1:0]  strobe_reg, strobe_next;
  logic           halt_reg, halt_next;
  logic           ack_reg, ack_next;
  logic           err_reg, err_next;
  logic [31:0]    rdata_reg, rdata_next;
  logic           we_reg, we_next;
  logic [23:0]    addr_reg, addr_next;
  logic [31:0]    wdata_reg, wdata_next;

  logic [3:0]     sel;
  logic [NT-1:0]  hit;
  logic [31:0]    slice [NT];
  logic           valid;
  logic           req;
  logic           ack_sel;
  logic [31:0]    rd_data;
  logic           addr_unused;

  assign sel         = wb_addr_i[27:24];
  assign req         = wb_cyc_i & wb_strobe_i;
  assign valid       = |hit;
  assign addr_unused = &{1'b0, wb_addr_i[31:28]};

  // ROMs decode from sel 0 upward, RAMs from sel 8 upward.
  genvar gi;
  generate
    for (gi = 0; gi < NT; gi++) begin : g_target
      if (gi < NUM_ROMS) begin : g_rom
        assign hit[gi] = (sel == 4'(gi));
      end else begin : g_ram
        assign hit[gi] = (sel == 4'(8 + gi - NUM_ROMS));
      end
      assign slice[gi] = tgt_data_i[32*gi +: 32];
    end
  endgenerate

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NT; k++) begin
      if (sel_reg[k]) rd_data = rd_data | slice[k];
    end
  end

  assign ack_sel = |(tgt_ack_i & sel_reg);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      sel_reg    <= '0;
      strobe_reg <= '0;
      halt_reg   <= 1'b0;
      ack_reg    <= 1'b0;
      err_reg    <= 1'b0;
      rdata_reg  <= '0;
      we_reg     <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      sel_reg    <= sel_next;
      strobe_reg <= strobe_next;
      halt_reg   <= halt_next;
      ack_reg    <= ack_next;
      err_reg    <= err_next;
      rdata_reg  <= rdata_next;
      we_reg     <= we_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    sel_next    = sel_reg;
    strobe_next = '0;
    halt_next   = halt_reg;
    ack_next    = 1'b0;
    err_next    = 1'b0;
    rdata_next  = rdata_reg;
    we_next     = we_reg;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;

    case (state_reg)
      IDLE, HOLD: begin
        if (req) begin
          if (valid) begin
            sel_next   = hit;
            we_next    = wb_we_i;
            addr_next  = wb_addr_i[23:0];
            wdata_next = wb_data_i;
            // Already frozen in HOLD, so go straight to the target.
            if (state_reg == HOLD) begin
              state_next  = ACCESS;
              strobe_next = hit;
              cnt_next    = '0;
            end else begin
              state_next = SYNC_WAIT;
            end
          end else begin
            state_next = RESP;
            ack_next   = !TIMEOUT_EN;
            err_next   = TIMEOUT_EN;
            rdata_next = '0;
          end
        end else if (state_reg == HOLD) begin
          if (cnt_reg <= 16'd1) begin
            state_next = IDLE;
            halt_next  = 1'b0;
          end else begin
            cnt_next = cnt_reg - 16'd1;
          end
        end
      end

      SYNC_WAIT: begin
        if (!wb_cyc_i) begin
          state_next = IDLE;
        end else if (sync) begin
          state_next = SETTLE;
          halt_next  = 1'b1;
          cnt_next   = 16'(SETTLE_CYCLES);
        end
      end

      SETTLE: begin
        if (!wb_cyc_i) begin
          state_next = halt_reg ? HOLD : IDLE;
          cnt_next   = 16'(HOLD_CYCLES);
        end else if (cnt_reg <= 16'd1) begin
          state_next  = ACCESS;
          strobe_next = sel_reg;
          cnt_next    = '0;
        end else begin
          cnt_next = cnt_reg - 16'd1;
        end
      end

      ACCESS: begin
        if (!wb_cyc_i) begin
          state_next = halt_reg ? HOLD : IDLE;
          cnt_next   = 16'(HOLD_CYCLES);
        end else if (ack_sel) begin
          state_next = RESP;
          ack_next   = 1'b1;
          rdata_next = rd_data;
        end else if (TIMEOUT_EN && (cnt_reg >= 16'(TIMEOUT_CYCLES - 1))) begin
          state_next = RESP;
          err_next   = 1'b1;
          rdata_next = 32'hDEAD_BEEF;
        end else begin
          strobe_next = sel_reg;
          if (TIMEOUT_EN) cnt_next = cnt_reg + 16'd1;
        end
      end

      RESP: begin
        state_next = halt_reg ? HOLD : IDLE;
        cnt_next   = 16'(HOLD_CYCLES);
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign halt         = halt_reg;
  assign wb_ack_o     = ack_reg;
  assign wb_err_o     = err_reg;
  assign wb_data_o    = rdata_reg;
  assign tgt_cyc_o    = strobe_reg;
  assign tgt_strobe_o = strobe_reg;
  assign tgt_we_o     = we_reg;
  assign tgt_addr_o   = {8'h00, addr_reg};
  assign tgt_data_o   = wdata_reg;

endmodule

// File: doc/backdoor_arbiter.md
# backdoor_arbiter

Arbitrates one host Wishbone port onto the per-chip backdoor ports of the ROM and RAM models in the 4-bit CPU test system.
- Before forwarding any access it freezes the whole system through the shared `halt` line, aligned to an instruction-cycle boundary marked by `sync`.
- It then runs a single-beat transaction to the selected chip and returns the response to the host.
- It sits beside the CPU in the system top and drives the `wb_*` backdoor inputs and the `halt` net that is currently tied low.

## Interface
- `NUM_ROMS`, 5: number of ROM backdoors; targets 0..NUM_ROMS-1.
- `NUM_RAMS`, 2: number of RAM backdoors; targets NUM_ROMS..NUM_ROMS+NUM_RAMS-1. NT = NUM_ROMS+NUM_RAMS.
- `SETTLE_CYCLES`, 2: cycles `halt` is held before the first target access.
- `HOLD_CYCLES`, 8: idle cycles `halt` stays asserted after a response, to allow back-to-back accesses.
- `TIMEOUT_CYCLES`, 64: target ack timeout. Used only with the configuration macro.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low; reset is applied when `reset`==0 at a rising edge.
- `sync` in 1: CPU cycle-start pulse.
- `halt` out 1: system freeze.
- `wb_cyc_i`, `wb_strobe_i`, `wb_we_i` in 1 each: host Wishbone controls.
- `wb_addr_i`, `wb_data_i` in 32 each: host address and write data.
- `wb_data_o` out 32: host read data.
- `wb_ack_o` out 1: host acknowledge.
- `wb_err_o` out 1: host error.
- `tgt_cyc_o`, `tgt_strobe_o` out NT each: one-hot target select.
- `tgt_we_o` out 1: target write enable.
- `tgt_addr_o` out 32: target address, equal to {8'h0, wb_addr_i[23:0]}.
- `tgt_data_o` out 32: target write data.
- `tgt_data_i` in 32*NT: target k occupies bits [32k+31:32k].
- `tgt_ack_i` in NT: per-target acknowledge.

## Operation
- Request: `wb_cyc_i`&`wb_strobe_i` while in IDLE or HOLD.
- Decode `wb_addr_i[27:24]` (sel):
  - sel < NUM_ROMS selects target sel.
  - 8 ≤ sel < 8+NUM_RAMS selects target NUM_ROMS+(sel-8).
  - Any other value is invalid.
- Host address, data and we are captured at request acceptance and held constant through ACCESS.
- FSM states: IDLE, SYNC_WAIT, SETTLE, ACCESS, RESP, HOLD.
- IDLE:
  - Valid request → SYNC_WAIT.
  - Invalid request → RESP with data 0, no halt, no target strobe.
- SYNC_WAIT: `sync`==1 → SETTLE; `halt`=1 from the next cycle.
- SETTLE: count SETTLE_CYCLES cycles → ACCESS.
- ACCESS:
  - Drive `tgt_cyc_o`/`tgt_strobe_o` bit for the target.
  - On that target's `tgt_ack_i`: latch its data slice → RESP.
  - Acks from non-selected targets are ignored.
- RESP:
  - One cycle with `wb_ack_o`=1 and `wb_data_o` = latched data.
  - Next state is HOLD if `halt` is asserted, else IDLE.
- HOLD:
  - Counter loads HOLD_CYCLES.
  - Valid request → ACCESS directly; no sync wait, no settle.
  - Invalid request → RESP.
  - Counter reaching 0 → IDLE, with `halt`=0 from the next cycle.
- Host abort (`wb_cyc_i`==0 during SYNC_WAIT/SETTLE/ACCESS):
  - Target strobe drops next cycle; no ack is issued.
  - Go to HOLD if `halt`=1, else IDLE.
- Reset mid-operation: all outputs 0 next cycle and the state returns to IDLE. `halt` drops immediately, even mid-access.
- Output reset values: `halt`, `wb_ack_o`, `wb_err_o`, `wb_data_o`, `tgt_cyc_o`, `tgt_strobe_o`, `tgt_we_o`, `tgt_addr_o` and `tgt_data_o` are all 0.

## Timing
- All outputs are registered.
- `halt` rises exactly one cycle after the cycle in which `sync` is sampled high in SYNC_WAIT.
- First access latency, from request to `wb_ack_o`: wait for sync (≤8) + 1 + SETTLE_CYCLES + target ack latency + 1.
- Back-to-back access within HOLD: request to target strobe is 1 cycle.
- `wb_ack_o` is a single-cycle pulse.
- The host must drop `wb_strobe_i` after the ack or be treated as a new request.
- If `sync` is high in the same cycle the request is accepted, SYNC_WAIT still waits for the next `sync`.

## Configuration
- `BACKDOOR_TIMEOUT_EN` defined:
  - ACCESS counts cycles. At TIMEOUT_CYCLES without ack: drop the target strobe, go to RESP with `wb_err_o`=1, `wb_ack_o`=0, data 32'hDEADBEEF.
  - Invalid target decode also responds with `wb_err_o`=1 instead of `wb_ack_o`.
- Macro undefined:
  - No counter; ACCESS waits indefinitely.
  - `wb_err_o` is tied 0.
  - Invalid decode acks with data 0.

## Test plan
- Read ROM 2 (addr 32'h0200_0010), target acks after 3 cycles with 32'h0000_00A5 → `halt` rises 1 cycle after `sync`, only `tgt_strobe_o[2]` is asserted, `wb_data_o`=32'hA5 with a one-cycle ack.
- Write RAM 1 (addr 32'h0900_0004, data 32'h7) → `tgt_strobe_o[6]`=1, `tgt_we_o`=1, `tgt_addr_o`=32'h0000_0004, `tgt_data_o`=32'h7.
- Two reads spaced 3 cycles apart → second strobe 1 cycle after its request, no second sync wait; `halt` falls HOLD_CYCLES+1 cycles after the second ack.
- Invalid address 32'h0F00_0000 → response 1 cycle after request, `halt` never asserted; with macro `wb_err_o`=1, without it `wb_ack_o`=1 and data 0.
- Target never acks, macro defined → `wb_err_o` after TIMEOUT_CYCLES, data 32'hDEADBEEF, strobe deasserted.
- `reset`=0 during ACCESS → next cycle `halt`=0, all `tgt_*` outputs 0; a fresh request then waits for `sync` again.
